// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer: state codes,
// program mask table, phase durations and display codes.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } state_e;

  localparam logic [5:0] DISP_EMPTY = 6'd55;
  localparam logic [5:0] DISP_FULL  = 6'd56;
  localparam logic [5:0] DISP_PAUSE = 6'd57;

  // Mask bit 7-k set means phase k is part of the program.
  function automatic logic [7:0] prog_mask(input logic [1:0] prog);
    case (prog)
      2'd0:    prog_mask = 8'hFF;
      2'd1:    prog_mask = 8'hC3;
      2'd2:    prog_mask = 8'h3F;
      default: prog_mask = 8'h03;
    endcase
  endfunction

  function automatic logic [7:0] phase_dur(input logic [2:0] idx,
                                           input logic [7:0] fill,
                                           input logic [7:0] wash,
                                           input logic [7:0] drain,
                                           input logic [7:0] spin,
                                           input logic [7:0] rinse);
    case (idx)
      3'd0, 3'd4: phase_dur = fill;
      3'd1:       phase_dur = wash;
      3'd2, 3'd6: phase_dur = drain;
      3'd3, 3'd7: phase_dur = spin;
      default:    phase_dur = rinse;
    endcase
  endfunction

endpackage

// File: rtl/sec_divider.sv
// 1 Hz time base: counter 0..SEC_DIV-1, one-cycle tick on the wrap cycle,
// 50% duty square wave. clr restarts both counter and square wave.
module sec_divider #(
  parameter int SEC_DIV = 50_000_000
) (
  input  logic cp,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic second
);

  localparam int CW = (SEC_DIV > 2) ? $clog2(SEC_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SEC_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(SEC_DIV / 2 - 1);

  logic [CW-1:0] cnt_q;
  logic          second_q;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      second_q <= 1'b0;
    end else if (clr) begin
      cnt_q    <= '0;
      second_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == LAST || cnt_q == HALF) second_q <= ~second_q;
    end
  end

  assign tick   = (cnt_q == LAST) && !clr;
  assign second = second_q;

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program controller: phase sequencing, timers and display digits.
// Optional WASH_BUZZER_EN adds a buzzer output driven in finish and on error entry.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int SEC_DIV   = 50_000_000,
  parameter int FILL_SEC  = 3,
  parameter int WASH_SEC  = 9,
  parameter int DRAIN_SEC = 3,
  parameter int SPIN_SEC  = 3,
  parameter int RINSE_SEC = 6,
  parameter int SHOW_SEC  = 2
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       start_btn,
  input  logic       mode_btn,
  input  logic       door_open,
  output logic [2:0] state,
  output logic [9:0] data,
  output logic [2:0] shinning,
  output logic       second,
  output logic [5:0] in_left,
  output logic [5:0] in_middle,
  output logic [5:0] in_right
`ifdef WASH_BUZZER_EN
  ,
  output logic       buzzer
`endif
);

  state_e     state_q;
  logic       pwr_q, start_q, mode_q;
  logic [7:0] mask_q, ptime_q, total_q, show_q;
  logic [1:0] prog_q;
  logic [2:0] phase_q;

  logic       tick, sec_w, clr_w;
  logic       pwr_e, start_e, mode_e;
  logic [7:0] mask_d, disp_w;
  logic [2:0] next_phase_d, first_phase_d;

  function automatic logic [7:0] dur(input logic [2:0] idx);
    dur = phase_dur(idx, 8'(FILL_SEC), 8'(WASH_SEC), 8'(DRAIN_SEC),
                    8'(SPIN_SEC), 8'(RINSE_SEC));
  endfunction

  // Lowest pending phase index is the one that runs next.
  function automatic logic [2:0] first_phase(input logic [7:0] m);
    first_phase = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[7-i]) first_phase = 3'(i);
  endfunction

  function automatic logic [7:0] mask_total(input logic [7:0] m);
    mask_total = 8'd0;
    for (int i = 0; i < 8; i++) if (m[7-i]) mask_total = mask_total + dur(3'(i));
  endfunction

  assign pwr_e         = power_btn & ~pwr_q;
  assign start_e       = start_btn & ~start_q;
  assign mode_e        = mode_btn & ~mode_q;
  assign clr_w         = pwr_e && (state_q == ST_SHUTDOWN);
  assign mask_d        = mask_q & ~(8'h80 >> phase_q);
  assign next_phase_d  = first_phase(mask_d);
  assign first_phase_d = first_phase(mask_q);

  sec_divider #(.SEC_DIV(SEC_DIV)) u_div (
    .cp     (cp),
    .rst_n  (rst_n),
    .clr    (clr_w),
    .tick   (tick),
    .second (sec_w)
  );

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SHUTDOWN;
      pwr_q   <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      prog_q  <= '0;
      phase_q <= '0;
      ptime_q <= '0;
      total_q <= '0;
      show_q  <= '0;
    end else begin
      pwr_q   <= power_btn;
      start_q <= start_btn;
      mode_q  <= mode_btn;
      if (pwr_e) begin
        state_q <= (state_q == ST_SHUTDOWN) ? ST_BEGIN : ST_SHUTDOWN;
        mask_q  <= '0;
        prog_q  <= '0;
        phase_q <= '0;
        ptime_q <= '0;
        total_q <= '0;
        show_q  <= 8'(SHOW_SEC);
      end else begin
        case (state_q)
          ST_BEGIN, ST_FINISH: if (tick) begin
            show_q <= show_q - 8'd1;
            if (show_q == 8'd1) begin
              state_q <= ST_SET;
              mask_q  <= prog_mask(prog_q);
            end
          end
          ST_SET: if (!door_open) begin
            if (start_e) begin
              state_q <= ST_RUN;
              total_q <= mask_total(mask_q);
              phase_q <= first_phase_d;
              ptime_q <= dur(first_phase_d);
            end else if (mode_e) begin
              prog_q <= prog_q + 2'd1;
              mask_q <= prog_mask(prog_q + 2'd1);
            end
          end
          ST_RUN: begin
            if (door_open) state_q <= ST_ERROR;
            else if (start_e) state_q <= ST_PAUSE;
            else if (tick) begin
              total_q <= total_q - 8'd1;
              ptime_q <= ptime_q - 8'd1;
              if (ptime_q == 8'd1) begin
                mask_q <= mask_d;
                if (mask_d == 8'd0) begin
                  state_q <= ST_FINISH;
                  show_q  <= 8'(SHOW_SEC);
                end else begin
                  phase_q <= next_phase_d;
                  ptime_q <= dur(next_phase_d);
                end
              end
            end
          end
          ST_PAUSE: begin
            if (door_open) state_q <= ST_ERROR;
            else if (start_e) state_q <= ST_RUN;
          end
          ST_ERROR: if (!door_open && start_e) state_q <= ST_RUN;
          default: ;
        endcase
      end
    end
  end

`ifdef WASH_BUZZER_EN
  logic err_pulse_q;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) err_pulse_q <= 1'b0;
    else if (pwr_e) err_pulse_q <= 1'b0;
    else if ((state_q == ST_RUN || state_q == ST_PAUSE) && door_open) err_pulse_q <= 1'b1;
    else if (tick) err_pulse_q <= 1'b0;
  end

  assign buzzer = ((state_q == ST_FINISH) && sec_w) || err_pulse_q;
`endif

  assign disp_w    = (total_q > 8'd99) ? 8'd99 : total_q;
  assign state     = state_q;
  assign data      = {state_q == ST_SET, state_q != ST_SHUTDOWN, mask_q};
  assign shinning  = phase_q;
  assign second    = sec_w;
  assign in_left   = 6'(disp_w / 8'd10);
  assign in_middle = 6'(disp_w % 8'd10);
  assign in_right  = {4'd0, prog_q};

endmodule
